regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// The optional bypass comparators are enabled by the WB_BYPASS_EN macro.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // One writeback request as presented by a producer (ALU or LSU).
  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  // Output stage state: IDLE has nothing to write, WRITE drives the port.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is the ALU, bit 1 is the LSU.
// The pointer names the requester that wins a tie and always moves to the
// requester that lost the most recent grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic       stall,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant logic: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt = 2'b00;
    if (!stall && !clear) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer register: moves only on an actual grant, ALU favoured after clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (clear)
      ptr <= 1'b0;
    else if (gnt != 2'b00)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks one of two producers per cycle (round robin) and
// registers the accepted write onto the register-file write port one cycle
// later. Writes to register 0 are accepted but dropped.
// Optional macro WB_BYPASS_EN adds read-port bypass comparators.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              stall,
  output logic              write,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] WD,
  output logic              busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] RR1,
  input  logic [ADDR_W-1:0] RR2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp_data
`endif
);

  wb_state_t         state, state_nxt;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              load;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .clear (clear),
    .req   ({lsu_valid, alu_valid}),
    .stall (stall),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];

  // Select the granted request; load only when it targets a real register.
  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (gnt[1]) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end
    load = (gnt != 2'b00) && (sel_rd != '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clear)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state: any cycle with a loadable acceptance goes (or stays) in WRITE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = load ? WRITE : IDLE;
      WRITE:   state_nxt = load ? WRITE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: captures the accepted write, holds it while idle.
  always_ff @(posedge clk) begin
    // NOTE: the write-address/data register is cleared as well, so the port
    // shows zeros rather than stale data after a reset.
    if (clear) begin
      WR <= '0;
      WD <= '0;
    end else if (load) begin
      WR <= sel_rd;
      WD <= sel_data;
    end
  end

  assign write = (state == WRITE);
  assign busy  = (state == WRITE);

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to read ports that name the same register.
  assign byp1_hit = write && (WR == RR1) && (RR1 != '0);
  assign byp2_hit = write && (WR == RR2) && (RR2 != '0);
  assign byp_data = WD;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter (default widths).
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic        clk;
  logic        clear;
  logic        alu_valid, lsu_valid, stall;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        write, busy;
  logic [4:0]  WR;
  logic [31:0] WD;
`ifdef WB_BYPASS_EN
  logic [4:0]  RR1, RR2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp_data;
`endif

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .clear     (clear),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .stall     (stall),
    .write     (write),
    .WR        (WR),
    .WD        (WD),
    .busy      (busy)
`ifdef WB_BYPASS_EN
    ,
    .RR1       (RR1),
    .RR2       (RR2),
    .byp1_hit  (byp1_hit),
    .byp2_hit  (byp2_hit),
    .byp_data  (byp_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic do_reset();
    clear = 1'b1; stall = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; stall = 1'b0;
    drive_alu(1'b1, 5'd3, 32'h11);
    drive_lsu(1'b1, 5'd4, 32'h22);
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", {alu_ready, lsu_ready}); end
    tick();
    tests++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write: got %b want 0", write); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (WR !== 5'd0) begin fails++; $display("FAIL reset_WR: got %0d want 0", WR); end
    tests++; if (WD !== 32'h0) begin fails++; $display("FAIL reset_WD: got %h want 0", WD); end
    clear = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_single();
    do_reset();
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b10) begin fails++; $display("FAIL single_alu_ready: got %b want 10", {alu_ready, lsu_ready}); end
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    tests++; if (write !== 1'b1) begin fails++; $display("FAIL single_write: got %b want 1", write); end
    tests++; if (WR !== 5'd5) begin fails++; $display("FAIL single_WR: got %0d want 5", WR); end
    tests++; if (WD !== 32'hDEADBEEF) begin fails++; $display("FAIL single_WD: got %h want deadbeef", WD); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    tests++; if ({write, busy} !== 2'b00) begin fails++; $display("FAIL idle_write_busy: got %b want 00", {write, busy}); end
    tests++; if ({WR, WD} !== {5'd5, 32'hDEADBEEF}) begin fails++; $display("FAIL idle_hold: got %0d/%h want 5/deadbeef", WR, WD); end
    // Pointer now favours LSU; a lone ALU request must still win.
    drive_alu(1'b1, 5'd6, 32'h66);
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b10) begin fails++; $display("FAIL lone_alu_vs_ptr: got %b want 10", {alu_ready, lsu_ready}); end
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    // Pointer now favours LSU again; reset it and try a lone LSU.
    do_reset();
    drive_lsu(1'b1, 5'd9, 32'h99);
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b01) begin fails++; $display("FAIL lone_lsu_vs_ptr: got %b want 01", {alu_ready, lsu_ready}); end
    tick();
    drive_lsu(1'b0, 5'd0, 32'h0);
    tests++; if ({write, WR, WD} !== {1'b1, 5'd9, 32'h99}) begin fails++; $display("FAIL lone_lsu_write: got %b/%0d/%h want 1/9/99", write, WR, WD); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    do_reset();
    drive_alu(1'b1, 5'd1, 32'hA1A1A1A1);
    drive_lsu(1'b1, 5'd2, 32'hB2B2B2B2);
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_wr  = (i % 2 == 0) ? 5'd1 : 5'd2;
      exp_wd  = (i % 2 == 0) ? 32'hA1A1A1A1 : 32'hB2B2B2B2;
      #1;
      tests++; if ({alu_ready, lsu_ready} !== exp_rdy) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, {alu_ready, lsu_ready}, exp_rdy); end
      tick();
      tests++; if ({write, WR, WD} !== {1'b1, exp_wr, exp_wd}) begin fails++; $display("FAIL b2b_write[%0d]: got %b/%0d/%h want 1/%0d/%h", i, write, WR, WD, exp_wr, exp_wd); end
    end
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
    tick();
    tests++; if (write !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", write); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    drive_lsu(1'b1, 5'd0, 32'h1234);
    #1;
    tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL rd0_ready: got %b want 1", lsu_ready); end
    tick();
    drive_lsu(1'b0, 5'd0, 32'h0);
    tests++; if ({write, busy} !== 2'b00) begin fails++; $display("FAIL rd0_no_write: got %b want 00", {write, busy}); end
    // rd=0 following a real write: FSM leaves WRITE, port keeps old value.
    drive_alu(1'b1, 5'd4, 32'h44);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b1, 5'd0, 32'h5555);
    #1;
    tests++; if ({write, lsu_ready} !== 2'b11) begin fails++; $display("FAIL rd0_in_write: got %b want 11", {write, lsu_ready}); end
    tick();
    drive_lsu(1'b0, 5'd0, 32'h0);
    tests++; if ({write, WR, WD} !== {1'b0, 5'd4, 32'h44}) begin fails++; $display("FAIL rd0_after_write: got %b/%0d/%h want 0/4/44", write, WR, WD); end
  endtask

  task automatic test_stall();
    do_reset();
    drive_alu(1'b1, 5'd8, 32'h88);
    tick();
    // ALU granted, pointer now on LSU, output stage in WRITE.
    stall = 1'b1;
    drive_alu(1'b1, 5'd10, 32'hAA);
    drive_lsu(1'b1, 5'd11, 32'hBB);
    #1;
    tests++; if (write !== 1'b1) begin fails++; $display("FAIL stall_completes: got %b want 1", write); end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) #1;
      tests++; if ({alu_ready, lsu_ready} !== 2'b00) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {alu_ready, lsu_ready}); end
      tick();
      tests++; if (write !== 1'b0) begin fails++; $display("FAIL stall_idle[%0d]: got %b want 0", i, write); end
    end
    stall = 1'b0;
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b01) begin fails++; $display("FAIL post_stall_owner: got %b want 01", {alu_ready, lsu_ready}); end
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
    tests++; if ({write, WR, WD} !== {1'b1, 5'd11, 32'hBB}) begin fails++; $display("FAIL post_stall_write: got %b/%0d/%h want 1/11/bb", write, WR, WD); end
  endtask

  task automatic test_clear_in_write();
    do_reset();
    drive_alu(1'b1, 5'd7, 32'h77);
    tick();
    tests++; if ({write, WR} !== {1'b1, 5'd7}) begin fails++; $display("FAIL cw_loaded: got %b/%0d want 1/7", write, WR); end
    clear = 1'b1;
    drive_lsu(1'b1, 5'd3, 32'h33);
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b00) begin fails++; $display("FAIL cw_ready: got %b want 00", {alu_ready, lsu_ready}); end
    tick();
    clear = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    drive_lsu(1'b0, 5'd0, 32'h0);
    tests++; if ({write, busy, WR, WD} !== {1'b0, 1'b0, 5'd0, 32'h0}) begin fails++; $display("FAIL cw_discard: got %b/%b/%0d/%h want 0/0/0/0", write, busy, WR, WD); end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    RR1 = 5'd3; RR2 = 5'd0;
    drive_alu(1'b1, 5'd3, 32'hC0FFEE);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    tests++; if ({byp1_hit, byp2_hit, byp_data} !== {1'b1, 1'b0, 32'hC0FFEE}) begin fails++; $display("FAIL bypass: got %b/%b/%h want 1/0/c0ffee", byp1_hit, byp2_hit, byp_data); end
    tick();
    tests++; if (byp1_hit !== 1'b0) begin fails++; $display("FAIL bypass_idle: got %b want 0", byp1_hit); end
  endtask
`endif

  initial begin
    clear = 1'b1; stall = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
`ifdef WB_BYPASS_EN
    RR1 = '0; RR2 = '0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_rd_zero();
    test_stall();
    test_clear_in_write();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
